camera_scroll: RTL and testbench
================================

CAMERA_SCROLL -- requirements
Module: camera_scroll

Interface
REQ-001 Parameter VIEW_INIT, default 640: reset/initial camera right-edge position in pixels.
REQ-002 Parameter VIEW_MAX, default 13568: maximum view, equal to 212 map columns x 64 px.
REQ-003 Parameter STEP, default 16: pixels advanced per accepted scroll tick.
REQ-004 Parameter RIGHT_EDGE, default 640: mario_x at or beyond which the camera pushes right.
REQ-005 Parameter LEFT_EDGE, default 128: mario_x at or below which the camera pulls left; used only with SCROLL_BACK_EN.
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 tick  input  1  one-clk-cycle strobe at walk rate (10 Hz), already synchronous to clk.
REQ-009 left, right  input  1 each  player direction buttons, level.
REQ-010 hit_left, hit_right  input  1 each  collision flags from the world stage.
REQ-011 death  input  1  player dead, level.
REQ-012 mario_x  input  11  player screen x in pixels.
REQ-013 view  output  33  camera right-edge world x, registered; feeds the world stage.
REQ-014 scrolling  output  1  high for the cycle in which view changed.
REQ-015 col_strobe  output  1  one-cycle pulse when col_index changes.
REQ-016 col_index  output  8  (view - VIEW_INIT) / 64, registered.
REQ-017 level_end  output  1  sticky; high once view has reached VIEW_MAX.

Function
REQ-018 The FSM SHALL have states RUN, END and DEAD; the reset state is RUN.
REQ-019 In RUN, a forward push SHALL occur on a cycle with tick=1, right=1, left=0, hit_left=0, death=0 and mario_x >= RIGHT_EDGE.
REQ-020 A forward push SHALL set view <= min(view + STEP, VIEW_MAX) on the same clk edge that samples tick; latency is 1 cycle.
REQ-021 If a push makes view equal to VIEW_MAX, the FSM SHALL go to END and level_end SHALL go high on that same edge.
REQ-022 In END, view SHALL hold and no push SHALL be accepted.
REQ-023 death=1 in RUN or END SHALL move the FSM to DEAD next edge; DEAD SHALL freeze view, col_index and level_end until reset.
REQ-024 left=1 and right=1 together SHALL produce no push.
REQ-025 tick=0 SHALL produce no push regardless of the other inputs.
REQ-026 scrolling SHALL be 1 exactly on the edge where view's registered value changed, else 0.
REQ-027 col_index SHALL update on the same edge as view; col_strobe SHALL be 1 for that one cycle only if col_index differs from its previous value.
REQ-028 The view arithmetic SHALL be 33-bit unsigned; the clamp SHALL be computed before the register, so view never exceeds VIEW_MAX or falls below VIEW_INIT.

Reset
REQ-029 rst=0 SHALL immediately force view=VIEW_INIT, col_index=0, scrolling=0, col_strobe=0, level_end=0 and state RUN.
REQ-030 Reset asserted mid-scroll or in END/DEAD SHALL give the same values as REQ-029; the first push after release requires a fresh tick.

Configuration
REQ-031 Macro SCROLL_BACK_EN: when defined, RUN SHALL also accept a backward pull on a cycle with tick=1, left=1, right=0, hit_right=0, death=0 and mario_x <= LEFT_EDGE, setting view <= max(view - STEP, VIEW_INIT) and updating col_index and col_strobe as in REQ-027.
REQ-032 Without SCROLL_BACK_EN, view SHALL be monotonically non-decreasing and left SHALL never change view.
REQ-033 A backward pull SHALL NOT be accepted in END or DEAD.

Verification
REQ-034 Reset release, mario_x=640, right=1, 4 ticks -> view 640->656->672->688->704; col_strobe exactly once, at 704, with col_index=1.
REQ-035 view=13560, mario_x=640, right=1, one tick -> view=13568, level_end=1, state END; a further tick -> view stays 13568.
REQ-036 hit_left=1 or left=right=1 or mario_x=639 with tick -> view unchanged, scrolling=0.
REQ-037 death=1 at view=1000, then right+ticks -> view stays 1000; rst pulse -> view=640, level_end=0, col_index=0.
REQ-038 With SCROLL_BACK_EN, view=656, mario_x=128, left=1, 2 ticks -> view 640 then 640 (clamped); without the macro -> 656 unchanged.

Source files
------------

// File: rtl/camera_scroll.sv
// camera_scroll: side-scroller camera that tracks the player's right edge.
// The camera advances in STEP-pixel increments on walk ticks and clamps at VIEW_MAX.
// It also reports the 64-pixel map column index and a level-end flag.
// Optional feature macro: SCROLL_BACK_EN enables a backward pull toward VIEW_INIT.
module camera_scroll #(
    parameter int unsigned VIEW_INIT  = 640,
    parameter int unsigned VIEW_MAX   = 13568,
    parameter int unsigned STEP       = 16,
    parameter int unsigned RIGHT_EDGE = 640,
    parameter int unsigned LEFT_EDGE  = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        left,
    input  logic        right,
    input  logic        hit_left,
    input  logic        hit_right,
    input  logic        death,
    input  logic [10:0] mario_x,
    output logic [32:0] view,
    output logic        scrolling,
    output logic        col_strobe,
    output logic [7:0]  col_index,
    output logic        level_end
);

    localparam int unsigned VIEW_W = 33;
    localparam int unsigned X_W    = 11;
    localparam int unsigned COL_W  = 8;
    localparam int unsigned COL_SH = 6;

    localparam logic [VIEW_W-1:0] VIEW_INIT_V = VIEW_W'(VIEW_INIT);
    localparam logic [VIEW_W-1:0] VIEW_MAX_V  = VIEW_W'(VIEW_MAX);
    localparam logic [VIEW_W-1:0] STEP_V      = VIEW_W'(STEP);
    localparam logic [X_W-1:0]    RIGHT_X     = X_W'(RIGHT_EDGE);
    localparam logic [X_W-1:0]    LEFT_X      = X_W'(LEFT_EDGE);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_END  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [VIEW_W-1:0]  view_q, view_d;
    logic [COL_W-1:0]   col_index_q, col_index_d;
    logic               scrolling_q, scrolling_d;
    logic               col_strobe_q, col_strobe_d;
    logic               level_end_q, level_end_d;

    logic [VIEW_W-1:0]  view_fwd;
    logic [VIEW_W-1:0]  view_fwd_clamped;
    logic [VIEW_W-1:0]  view_back;
    logic [VIEW_W-1:0]  view_offset;
    logic               push_fwd;
    logic               pull_back;

    // Forward push qualification and clamped target position.
    assign push_fwd         = tick & right & ~left & ~hit_left & ~death & (mario_x >= RIGHT_X);
    assign view_fwd         = view_q + STEP_V;
    assign view_fwd_clamped = (view_fwd > VIEW_MAX_V) ? VIEW_MAX_V : view_fwd;

`ifdef SCROLL_BACK_EN
    // Backward pull qualification; floor at VIEW_INIT without wrapping below zero.
    assign pull_back = tick & left & ~right & ~hit_right & ~death & (mario_x <= LEFT_X);
    assign view_back = (view_q >= VIEW_INIT_V + STEP_V) ? (view_q - STEP_V) : VIEW_INIT_V;
`else
    // Camera never moves backward in this build.
    logic unused_back;
    assign pull_back   = 1'b0;
    assign view_back   = view_q;
    assign unused_back = ^{hit_right, LEFT_X};
`endif

    // Next-state, next-view and derived column/flag computation.
    always_comb begin
        state_d     = state_q;
        view_d      = view_q;
        level_end_d = level_end_q;

        case (state_q)
            ST_RUN: begin
                if (death) begin
                    state_d = ST_DEAD;
                end else if (push_fwd) begin
                    view_d = view_fwd_clamped;
                    if (view_fwd_clamped == VIEW_MAX_V) begin
                        state_d     = ST_END;
                        level_end_d = 1'b1;
                    end
                end else if (pull_back) begin
                    view_d = view_back;
                end
            end
            ST_END: begin
                if (death) begin
                    state_d = ST_DEAD;
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        view_offset  = view_d - VIEW_INIT_V;
        col_index_d  = COL_W'(view_offset >> COL_SH);
        scrolling_d  = (view_d != view_q);
        col_strobe_d = (col_index_d != col_index_q);
    end

    // State and registered outputs with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            view_q       <= VIEW_INIT_V;
            col_index_q  <= '0;
            scrolling_q  <= 1'b0;
            col_strobe_q <= 1'b0;
            level_end_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            view_q       <= view_d;
            col_index_q  <= col_index_d;
            scrolling_q  <= scrolling_d;
            col_strobe_q <= col_strobe_d;
            level_end_q  <= level_end_d;
        end
    end

    assign view       = view_q;
    assign scrolling  = scrolling_q;
    assign col_strobe = col_strobe_q;
    assign col_index  = col_index_q;
    assign level_end  = level_end_q;

endmodule

// File: tb/tb_camera_scroll.sv
// Testbench for camera_scroll: directed vector table plus multi-cycle sequences.
module tb_camera_scroll;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick, tick_e;
    logic        left, right, hit_left, hit_right, death;
    logic [10:0] mario_x;

    logic [32:0] view, view_e;
    logic        scrolling, scrolling_e;
    logic        col_strobe, col_strobe_e;
    logic [7:0]  col_index, col_index_e;
    logic        level_end, level_end_e;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    camera_scroll u_dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .left       (left),
        .right      (right),
        .hit_left   (hit_left),
        .hit_right  (hit_right),
        .death      (death),
        .mario_x    (mario_x),
        .view       (view),
        .scrolling  (scrolling),
        .col_strobe (col_strobe),
        .col_index  (col_index),
        .level_end  (level_end)
    );

    // Second camera starting 8 px short of the end, for the clamp/END corner.
    camera_scroll #(.VIEW_INIT(13560)) u_end (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick_e),
        .left       (left),
        .right      (right),
        .hit_left   (hit_left),
        .hit_right  (hit_right),
        .death      (death),
        .mario_x    (mario_x),
        .view       (view_e),
        .scrolling  (scrolling_e),
        .col_strobe (col_strobe_e),
        .col_index  (col_index_e),
        .level_end  (level_end_e)
    );

    typedef struct {
        logic        tick;
        logic        left;
        logic        right;
        logic        hit_l;
        logic        hit_r;
        logic        death;
        logic [10:0] mx;
        logic [32:0] e_view;
        logic        e_scr;
        logic        e_cs;
        logic [7:0]  e_ci;
        logic        e_le;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic t, input logic l, input logic r, input logic hl,
                         input logic hr, input logic d, input logic [10:0] mx);
        tick = t; left = l; right = r; hit_left = hl; hit_right = hr; death = d; mario_x = mx;
    endtask

    task automatic check_main(input string tag, input logic [32:0] ev, input logic es,
                              input logic ecs, input logic [7:0] eci, input logic ele);
        check({tag, ".view"},       view,       ev);
        check({tag, ".scrolling"},  33'(scrolling),  33'(es));
        check({tag, ".col_strobe"}, 33'(col_strobe), 33'(ecs));
        check({tag, ".col_index"},  33'(col_index),  33'(eci));
        check({tag, ".level_end"},  33'(level_end),  33'(ele));
    endtask

    initial begin
        //          tick l  r  hl hr d  mx         view  scr cs ci  le
        vecs[0]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,11'd640,  33'd640, 1'b0,1'b0,8'd0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,11'd640,  33'd656, 1'b1,1'b0,8'd0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,11'd640,  33'd656, 1'b0,1'b0,8'd0,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,11'd640,  33'd672, 1'b1,1'b0,8'd0,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,11'd640,  33'd688, 1'b1,1'b0,8'd0,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,11'd640,  33'd704, 1'b1,1'b1,8'd1,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,11'd640,  33'd704, 1'b0,1'b0,8'd1,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,11'd640,  33'd704, 1'b0,1'b0,8'd1,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,11'd640,  33'd704, 1'b0,1'b0,8'd1,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,11'd639,  33'd704, 1'b0,1'b0,8'd1,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,11'd2047, 33'd704, 1'b0,1'b0,8'd1,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,11'd640,  33'd704, 1'b0,1'b0,8'd1,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,11'd640,  33'd704, 1'b0,1'b0,8'd1,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,11'd2047, 33'd720, 1'b1,1'b0,8'd1,1'b0};
        vecs[14] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,11'd640,  33'd736, 1'b1,1'b0,8'd1,1'b0};

        rst = 1'b0;
        tick_e = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        repeat (2) @(negedge clk);
        check_main("reset", 33'd640, 1'b0, 1'b0, 8'd0, 1'b0);
        check("reset.view_e", view_e, 33'd13560);
        check("reset.level_end_e", 33'(level_end_e), 33'd0);
        rst = 1'b1;

        // Table: forward pushes, blocked pushes and column strobe.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].tick, vecs[i].left, vecs[i].right, vecs[i].hit_l,
                  vecs[i].hit_r, vecs[i].death, vecs[i].mx);
            @(negedge clk);
            check_main($sformatf("vec%0d", i), vecs[i].e_view, vecs[i].e_scr,
                       vecs[i].e_cs, vecs[i].e_ci, vecs[i].e_le);
        end

        // Death freezes the camera even after death is released.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd640);
        @(negedge clk);
        check_main("death0", 33'd736, 1'b0, 1'b0, 8'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd640);
            @(negedge clk);
            check_main($sformatf("dead%0d", i), 33'd736, 1'b0, 1'b0, 8'd1, 1'b0);
        end

        // Asynchronous reset between edges clears everything at once.
        #2 rst = 1'b0;
        #1 check_main("async_rst", 33'd640, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd640);
        rst = 1'b1;
        @(negedge clk);
        check_main("post_rst_idle", 33'd640, 1'b0, 1'b0, 8'd0, 1'b0);
        tick = 1'b1;
        @(negedge clk);
        check_main("post_rst_push", 33'd656, 1'b1, 1'b0, 8'd0, 1'b0);

        // Backward pull from 656 at the left edge.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd128);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
`ifdef SCROLL_BACK_EN
            check_main($sformatf("back%0d", i), 33'd640, (i == 0), 1'b0, 8'd0, 1'b0);
`else
            check_main($sformatf("back%0d", i), 33'd656, 1'b0, 1'b0, 8'd0, 1'b0);
`endif
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd640);

        // Clamp at VIEW_MAX: 13560 + 16 clamps to 13568 and enters END.
        check("end.init_view", view_e, 33'd13560);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd640);
        tick_e = 1'b1;
        @(negedge clk);
        check("end.view", view_e, 33'd13568);
        check("end.level_end", 33'(level_end_e), 33'd1);
        check("end.scrolling", 33'(scrolling_e), 33'd1);
        check("end.col_index", 33'(col_index_e), 33'd0);
        @(negedge clk);
        check("end.hold_view", view_e, 33'd13568);
        check("end.hold_scrolling", 33'(scrolling_e), 33'd0);
        check("end.hold_level_end", 33'(level_end_e), 33'd1);
        death = 1'b1;
        @(negedge clk);
        death = 1'b0;
        @(negedge clk);
        check("dead_end.view", view_e, 33'd13568);
        check("dead_end.level_end", 33'(level_end_e), 33'd1);
        tick_e = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("end_rst.view", view_e, 33'd13560);
        check("end_rst.level_end", 33'(level_end_e), 33'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
